s2_writeback_rx: RTL and testbench

- Return-path receiver for the two-stage pipeline. Runs entirely on fast_clk.
- Samples the divided slow_clk as data and detects each stage-2 launch edge.
- Waits for stage 2's variable-delay result, captures it into a small FIFO, and presents it downstream on a valid/ready interface.
- Generates s1_stall back-pressure toward stage 1 and sticky error flags for missing or dropped results.

---
 rtl/s2_writeback_rx_if.sv | 24 ++
 rtl/s2_writeback_rx.sv | 216 +++++++++++++++++++++
 tb/tb_s2_writeback_rx.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/s2_writeback_rx_if.sv
// Downstream result stream of the stage-2 writeback receiver.
// The receiver drives data/valid through the master modport; the consumer
// returns ready through the slave modport.
interface s2_writeback_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Producer side: presents the FIFO head and samples the consumer's ready.
    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Consumer side: takes the head when valid and ready are both high.
    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/s2_writeback_rx.sv
// Return-path receiver for the two-stage pipeline.
// Samples slow_clk as data on fast_clk, opens a wait window on every stage-2
// launch edge, captures the variable-delay s2_result into a small circular
// FIFO and presents it downstream on a valid/ready stream. Back-pressure to
// stage 1 and sticky error flags for lost or missing results are also
// generated here.
module s2_writeback_rx #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,   // power of 2, at least 2
    parameter int TIMEOUT = 15   // 1..255 fast_clk cycles
) (
    input  logic                     fast_clk,
    input  logic                     rst_n,
    input  logic                     slow_clk,
    input  logic [DATA_W-1:0]        s2_result,
    input  logic                     s2_done,
    s2_writeback_rx_if.master        out_if,
    output logic                     s1_stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     timeout_err,
    output logic                     overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Last counter value that still counts as "in time"; reaching it with
    // no s2_done abandons the transaction.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [7:0] WAIT_SAT     = 8'hFF;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,   // no launch outstanding
        ST_WAIT = 1'b1    // launch seen, waiting for s2_done
    } state_t;

    // ------------------------------------------------------------------
    // Launch-edge detection
    // ------------------------------------------------------------------
    logic slow_q;
    logic rise;

    assign rise = slow_clk & ~slow_q;

    // Delay slow_clk by one fast cycle so a rise is seen the first cycle it
    // samples high.
    // NOTE: every clocked block uses non-blocking assignments so all
    // registers see pre-edge values regardless of block evaluation order.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            slow_q <= 1'b0;
        end else begin
            slow_q <= slow_clk;
        end
    end

    // ------------------------------------------------------------------
    // Wait-window FSM
    // ------------------------------------------------------------------
    state_t     state;
    state_t     state_nx;
    logic [7:0] wait_cnt;
    logic       cnt_clr;
    logic       push_req;
    logic       set_timeout;

    // State register.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and per-cycle actions; s2_done outranks a new launch,
    // which outranks the timeout.
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nx    = state;
        cnt_clr     = 1'b0;
        push_req    = 1'b0;
        set_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                // A stray s2_done with no launch outstanding is ignored.
                if (rise) begin
                    state_nx = ST_WAIT;
                    cnt_clr  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (s2_done) begin
                    // A rise in this same cycle is deliberately dropped.
                    push_req = 1'b1;
                    state_nx = ST_IDLE;
                end else if (rise) begin
                    // Overrun: the previous launch never returned.
                    set_timeout = 1'b1;
                    cnt_clr     = 1'b1;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    set_timeout = 1'b1;
                    state_nx    = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Saturating wait counter; restarted on each launch.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if (cnt_clr) begin
            wait_cnt <= 8'd0;
        end else if (state == ST_WAIT && wait_cnt != WAIT_SAT) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nx;
    logic [CNT_W-1:0]  count_nx;
    logic [DATA_W-1:0] head_nx;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    assign full = (count == CNT_FULL);
    assign pop  = out_if.out_valid & out_if.out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    assign rd_ptr_nx = rd_ptr + PTR_W'(pop);

    // Occupancy after this edge.
    always_comb begin
        count_nx = count;
        if (push && !pop) begin
            count_nx = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nx = count - CNT_ONE;
        end
    end

    // Head value after this edge; the entry being written this cycle is
    // forwarded when it is about to become the head.
    always_comb begin
        head_nx = mem[rd_ptr_nx];
        if (push && (wr_ptr == rd_ptr_nx)) begin
            head_nx = s2_result;
        end
    end

    // Storage array write.
    // NOTE: the storage array has no reset; the pointers and count define
    // which entries are live, so clearing the data would buy nothing.
    always_ff @(posedge fast_clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= s2_result;
        end
    end

    // Pointers, occupancy and the registered output stage.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr           <= rd_ptr_nx;
            count            <= count_nx;
            out_if.out_valid <= (count_nx != '0);
            // Hold the last value when the FIFO drains to empty.
            if (count_nx != '0) begin
                out_if.out_data <= head_nx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign s1_stall = (count >= CNT_STALL);

    // Sticky error flags; only reset clears them.
    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            timeout_err  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            timeout_err  <= timeout_err  | set_timeout;
            overflow_err <= overflow_err | drop;
        end
    end

endmodule

// File: tb/tb_s2_writeback_rx.sv
// Self-checking bench for s2_writeback_rx: a queue-based transaction model
// is compared against the DUT on every falling edge, directed scenarios pin
// the model with literal values, and a randomized phase follows.
module tb_s2_writeback_rx;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              fast_clk  = 1'b0;
    logic              rst_n     = 1'b0;
    logic              slow_clk  = 1'b0;
    logic [DATA_W-1:0] s2_result = '0;
    logic              s2_done   = 1'b0;
    logic              out_ready = 1'b0;
    logic              s1_stall;
    logic [2:0]        count;
    logic              timeout_err;
    logic              overflow_err;

    s2_writeback_rx_if #(.DATA_W(DATA_W)) out_if ();
    assign out_if.out_ready = out_ready;

    s2_writeback_rx #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .fast_clk    (fast_clk),
        .rst_n       (rst_n),
        .slow_clk    (slow_clk),
        .s2_result   (s2_result),
        .s2_done     (s2_done),
        .out_if      (out_if),
        .s1_stall    (s1_stall),
        .count       (count),
        .timeout_err (timeout_err),
        .overflow_err(overflow_err)
    );

    always #5 fast_clk = ~fast_clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: one outstanding launch, a queue of results.
    // ------------------------------------------------------------------
    bit                m_slow_prev = 1'b0;
    bit                m_busy      = 1'b0;
    int                m_age       = 0;     // cycles already waited
    bit                m_to        = 1'b0;
    bit                m_of        = 1'b0;
    logic [DATA_W-1:0] m_q[$];

    always @(posedge fast_clk) begin : model
        bit rise;
        bit pop;
        bit was_full;
        if (!rst_n) begin
            m_slow_prev = 1'b0;
            m_busy      = 1'b0;
            m_age       = 0;
            m_to        = 1'b0;
            m_of        = 1'b0;
            m_q.delete();
        end else begin
            rise        = slow_clk && !m_slow_prev;
            m_slow_prev = slow_clk;
            pop         = (m_q.size() > 0) && out_ready;
            was_full    = (m_q.size() == DEPTH);
            if (pop) void'(m_q.pop_front());
            if (!m_busy) begin
                if (rise) begin
                    m_busy = 1'b1;
                    m_age  = 0;
                end
            end else if (s2_done) begin
                m_busy = 1'b0;
                if (was_full && !pop) m_of = 1'b1;
                else m_q.push_back(s2_result);
            end else if (rise) begin
                m_to  = 1'b1;
                m_age = 0;
            end else if (m_age + 1 >= TIMEOUT) begin
                m_to   = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_age++;
            end
        end
    end

    // Compare the DUT against the model mid-cycle, every cycle.
    always @(negedge fast_clk) begin
        if (cmp_en) begin
            check("count", count, m_q.size());
            check("out_valid", out_if.out_valid, m_q.size() != 0);
            if (m_q.size() != 0) check("out_data", out_if.out_data, m_q[0]);
            check("s1_stall", s1_stall, m_q.size() >= DEPTH - 1);
            check("timeout_err", timeout_err, m_to);
            check("overflow_err", overflow_err, m_of);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all return just after a falling edge)
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge fast_clk);
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        slow_clk  = 1'b0;
        s2_done   = 1'b0;
        out_ready = 1'b0;
        cyc(n);
        rst_n = 1'b1;
    endtask

    task automatic launch();
        slow_clk = 1'b1;
        cyc(1);
        slow_clk = 1'b0;
    endtask

    task automatic done(input logic [DATA_W-1:0] v);
        s2_result = v;
        s2_done   = 1'b1;
        cyc(1);
        s2_done = 1'b0;
    endtask

    task automatic transaction(input logic [DATA_W-1:0] v);
        launch();
        cyc(2);
        done(v);
    endtask

    logic [DATA_W-1:0] tail_seq [4] = '{8'h08, 8'h07, 8'h06, 8'h55};

    initial begin
        cyc(1);
        cmp_en = 1'b1;

        // Basic return.
        do_reset(4);
        check("rst_count", count, 0);
        check("rst_valid", out_if.out_valid, 0);
        check("rst_data", out_if.out_data, 0);
        check("rst_stall", s1_stall, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_oerr", overflow_err, 0);
        out_ready = 1'b1;
        transaction(8'h2A);
        check("basic_valid", out_if.out_valid, 1);
        check("basic_data", out_if.out_data, 8'h2A);
        cyc(1);
        check("basic_count", count, 0);
        check("basic_valid_low", out_if.out_valid, 0);
        check("basic_terr", timeout_err, 0);
        check("basic_oerr", overflow_err, 0);

        // Back-pressure and overflow.
        do_reset(2);
        for (int v = 1; v <= 4; v++) begin
            transaction(DATA_W'(v));
            if (v == 2) check("bp_stall_c2", s1_stall, 0);
            if (v == 3) check("bp_stall_c3", s1_stall, 1);
        end
        check("bp_count4", count, 4);
        transaction(8'h05);
        check("bp_oerr", overflow_err, 1);
        check("bp_count_full", count, 4);
        out_ready = 1'b1;
        for (int v = 1; v <= 4; v++) begin
            check("bp_drain", out_if.out_data, v);
            cyc(1);
            if (v == 1) check("bp_stall_c3_drain", s1_stall, 1);
            if (v == 2) check("bp_stall_c2_drain", s1_stall, 0);
        end
        check("bp_empty", count, 0);

        // Timeout.
        do_reset(2);
        launch();
        cyc(TIMEOUT - 1);
        check("to_not_yet", timeout_err, 0);
        cyc(1);
        check("to_set", timeout_err, 1);
        done(8'h77);
        check("to_ignored_count", count, 0);
        check("to_ignored_valid", out_if.out_valid, 0);

        // Overrun by a second launch.
        do_reset(2);
        launch();
        cyc(7);
        check("ovr_before", timeout_err, 0);
        launch();
        cyc(1);
        done(8'h10);
        check("ovr_terr", timeout_err, 1);
        check("ovr_data", out_if.out_data, 8'h10);
        check("ovr_count", count, 1);

        // Full FIFO with simultaneous push and pop.
        do_reset(2);
        transaction(8'h09);
        transaction(8'h08);
        transaction(8'h07);
        transaction(8'h06);
        launch();
        cyc(2);
        s2_result = 8'h55;
        s2_done   = 1'b1;
        out_ready = 1'b1;
        check("pp_head", out_if.out_data, 8'h09);
        cyc(1);
        s2_done = 1'b0;
        check("pp_count", count, 4);
        check("pp_oerr", overflow_err, 0);
        for (int i = 0; i < 4; i++) begin
            check("pp_order", out_if.out_data, tail_seq[i]);
            cyc(1);
        end
        check("pp_empty", count, 0);

        // Reset in the middle of a wait with data queued.
        do_reset(2);
        transaction(8'hA1);
        transaction(8'hA2);
        launch();
        cyc(2);
        check("mid_count", count, 2);
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        check("mid_count0", count, 0);
        check("mid_valid0", out_if.out_valid, 0);
        check("mid_terr0", timeout_err, 0);
        check("mid_oerr0", overflow_err, 0);
        done(8'h33);
        check("mid_ignored", count, 0);
        transaction(8'h44);
        check("mid_after", out_if.out_data, 8'h44);
        check("mid_after_count", count, 1);

        // Randomized traffic against the model.
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            int seg;
            seg       = (i / 250) % 4;
            out_ready = ($urandom_range(0, 3) < seg);
            if ($urandom_range(0, 5) == 0) slow_clk = ~slow_clk;
            s2_done   = ($urandom_range(0, 7) == 0);
            s2_result = DATA_W'($urandom);
            rst_n     = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        rst_n   = 1'b1;
        s2_done = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
